// File: rtl/counter_ctrl.sv
// Run controller for an external up/down counter: loads the reload value once per
// period, counts periods on ovf_in and signals period and run completion.
module counter_ctrl #(
    parameter int counter_size = 32
) (
    input  logic                    clk,
    input  logic                    res_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    hold,
    input  logic                    dir_cfg,
    input  logic [counter_size-1:0] reload_val,
    input  logic [7:0]              repeat_num,
    input  logic                    ovf_in,
    output logic                    ctr_enable,
    output logic                    ctr_load,
    output logic                    ctr_dir,
    output logic [counter_size-1:0] ctr_cnt_in,
    output logic                    busy,
    output logic                    period_evt,
    output logic                    done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t                  state_r;
    state_t                  next_s;
    logic                    ovf_take_s;
    logic [7:0]              remaining_r;
    logic                    ctr_enable_r;
    logic                    ctr_load_r;
    logic                    ctr_dir_r;
    logic [counter_size-1:0] ctr_cnt_in_r;
    logic                    busy_r;
    logic                    period_evt_r;
    logic                    done_r;

    // Next-state decode; stop outranks an overflow arriving in the same cycle.
    always_comb begin
        next_s     = state_r;
        ovf_take_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_s = LOAD;
                end else begin
                    next_s = IDLE;
                end
            end
            LOAD: begin
                if (stop) begin
                    next_s = IDLE;
                end else begin
                    next_s = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    next_s = IDLE;
                end else if (ovf_in) begin
                    ovf_take_s = 1'b1;
                    if (remaining_r == 8'd1) begin
                        next_s = FINISH;
                    end else begin
                        next_s = LOAD;
                    end
                end else begin
                    next_s = RUN;
                end
            end
            FINISH: begin
                next_s = IDLE;
            end
            default: begin
                next_s = IDLE;
            end
        endcase
    end

    // State, latched run configuration and outputs registered from the next state.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state_r      <= IDLE;
            remaining_r  <= 8'd0;
            ctr_enable_r <= 1'b0;
            ctr_load_r   <= 1'b0;
            ctr_dir_r    <= 1'b0;
            ctr_cnt_in_r <= '0;
            busy_r       <= 1'b0;
            period_evt_r <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            state_r      <= next_s;
            busy_r       <= (next_s != IDLE);
            ctr_load_r   <= (next_s == LOAD);
            ctr_enable_r <= (next_s == RUN) && !hold;
            period_evt_r <= ovf_take_s;
            done_r       <= (next_s == FINISH);
            if ((state_r == IDLE) && start) begin
                ctr_dir_r    <= dir_cfg;
                ctr_cnt_in_r <= reload_val;
                remaining_r  <= repeat_num;
            end else if (ovf_take_s && (remaining_r != 8'd0)) begin
                // A zero count means an endless run and is never decremented.
                remaining_r <= remaining_r - 8'd1;
            end else begin
                remaining_r <= remaining_r;
            end
        end
    end

    assign ctr_enable = ctr_enable_r;
    assign ctr_load   = ctr_load_r;
    assign ctr_dir    = ctr_dir_r;
    assign ctr_cnt_in = ctr_cnt_in_r;
    assign busy       = busy_r;
    assign period_evt = period_evt_r;
    assign done       = done_r;

endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl: stimulus queues expected load/period/done
// pulses, a negedge monitor pops and compares them as the DUT emits them.
module tb_counter_ctrl;

    logic        clk = 1'b0;
    logic        res_n = 1'b1;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic        hold = 1'b0;
    logic        dir_cfg = 1'b0;
    logic [31:0] reload_val = 32'd0;
    logic [7:0]  repeat_num = 8'd0;
    logic        ovf_in = 1'b0;
    logic        ctr_enable;
    logic        ctr_load;
    logic        ctr_dir;
    logic [31:0] ctr_cnt_in;
    logic        busy;
    logic        period_evt;
    logic        done;

    counter_ctrl #(.counter_size(32)) dut (
        .clk        (clk),
        .res_n      (res_n),
        .start      (start),
        .stop       (stop),
        .hold       (hold),
        .dir_cfg    (dir_cfg),
        .reload_val (reload_val),
        .repeat_num (repeat_num),
        .ovf_in     (ovf_in),
        .ctr_enable (ctr_enable),
        .ctr_load   (ctr_load),
        .ctr_dir    (ctr_dir),
        .ctr_cnt_in (ctr_cnt_in),
        .busy       (busy),
        .period_evt (period_evt),
        .done       (done)
    );

    always #5 clk = ~clk;

    localparam int K_LOAD   = 0;
    localparam int K_PERIOD = 1;
    localparam int K_DONE   = 2;

    typedef struct {
        int          kind;
        logic [31:0] cnt;
        logic        dir;
    } exp_t;

    exp_t q[$];
    int   vectors = 0;
    int   miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input int kind, input logic [31:0] cnt, input logic dir);
        exp_t e;
        e.kind = kind;
        e.cnt  = cnt;
        e.dir  = dir;
        q.push_back(e);
    endtask

    task automatic sb_pop(input int kind, input logic [31:0] cnt, input logic dir);
        exp_t e;
        vectors++;
        if (q.size() == 0) begin
            miscompares++;
            $display("FAIL sb_unexpected: got kind=%0d cnt=%h, expected no pulse", kind, cnt);
        end else begin
            e = q.pop_front();
            if ((e.kind != kind) || ((kind == K_LOAD) && ((e.cnt !== cnt) || (e.dir !== dir)))) begin
                miscompares++;
                $display("FAIL sb_event: got kind=%0d cnt=%h dir=%b expected kind=%0d cnt=%h dir=%b",
                         kind, cnt, dir, e.kind, e.cnt, e.dir);
            end
        end
    endtask

    // Monitor: every output pulse must match the next queued expectation.
    always @(negedge clk) begin
        if (res_n) begin
            if (period_evt) sb_pop(K_PERIOD, 32'd0, 1'b0);
            if (done)       sb_pop(K_DONE, 32'd0, 1'b0);
            if (ctr_load)   sb_pop(K_LOAD, ctr_cnt_in, ctr_dir);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic begin_run(input logic [31:0] rv, input logic d, input logic [7:0] rn);
        start      = 1'b1;
        reload_val = rv;
        dir_cfg    = d;
        repeat_num = rn;
        push(K_LOAD, rv, d);
        tick(1);
        start      = 1'b0;
        reload_val = 32'hDEAD_BEEF;
        dir_cfg    = ~d;
        repeat_num = 8'd7;
    endtask

    task automatic drained(input string name);
        check(name, q.size(), 32'd0);
    endtask

    initial begin
        // Reset state, asserted between edges
        #1 res_n = 1'b0;
        #2;
        check("reset_ctl", {26'd0, ctr_enable, ctr_load, ctr_dir, busy, period_evt, done}, 32'd0);
        check("reset_cnt", ctr_cnt_in, 32'd0);
        @(negedge clk) res_n = 1'b1;
        tick(1);

        // Single period
        begin_run(32'hFFFF_FFF0, 1'b0, 8'd1);
        check("sp_load", ctr_load, 32'd1);
        check("sp_en_in_load", ctr_enable, 32'd0);
        check("sp_cnt", ctr_cnt_in, 32'hFFFF_FFF0);
        tick(1);
        check("sp_en_rise", ctr_enable, 32'd1);
        tick(15);
        ovf_in = 1'b1;
        push(K_PERIOD, 32'd0, 1'b0);
        push(K_DONE, 32'd0, 1'b0);
        tick(1);
        ovf_in = 1'b0;
        check("sp_en_finish", ctr_enable, 32'd0);
        check("sp_busy_finish", busy, 32'd1);
        tick(1);
        check("sp_busy_idle", busy, 32'd0);
        drained("sp_drain");

        // Three periods, counting down
        begin_run(32'h0000_0100, 1'b1, 8'd3);
        tick(1);
        check("rp_dir", ctr_dir, 32'd1);
        for (int k = 0; k < 3; k++) begin
            tick(3);
            ovf_in = 1'b1;
            push(K_PERIOD, 32'd0, 1'b0);
            if (k < 2) push(K_LOAD, 32'h0000_0100, 1'b1);
            else       push(K_DONE, 32'd0, 1'b0);
            tick(1);
            ovf_in = 1'b0;
            if (k < 2) tick(1);
        end
        tick(1);
        check("rp_busy_idle", busy, 32'd0);
        drained("rp_drain");

        // Endless run, then stop
        begin_run(32'd5, 1'b0, 8'd0);
        tick(1);
        for (int k = 0; k < 5; k++) begin
            tick(2);
            ovf_in = 1'b1;
            push(K_PERIOD, 32'd0, 1'b0);
            push(K_LOAD, 32'd5, 1'b0);
            tick(1);
            ovf_in = 1'b0;
            tick(1);
        end
        check("en_busy", busy, 32'd1);
        stop = 1'b1;
        tick(1);
        stop = 1'b0;
        check("en_stop_busy", busy, 32'd0);
        check("en_stop_en", ctr_enable, 32'd0);
        drained("en_drain");

        // Hold for ten cycles, then stop colliding with ovf
        begin_run(32'd9, 1'b0, 8'd0);
        tick(2);
        hold = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            check("hold_en_low", ctr_enable, 32'd0);
        end
        hold = 1'b0;
        tick(1);
        check("hold_en_back", ctr_enable, 32'd1);
        stop   = 1'b1;
        ovf_in = 1'b1;
        tick(1);
        stop   = 1'b0;
        ovf_in = 1'b0;
        check("col_busy", busy, 32'd0);
        check("col_evt", {period_evt, done}, 32'd0);
        tick(2);
        drained("col_drain");

        // Start during run is ignored
        begin_run(32'h0000_AAAA, 1'b0, 8'd2);
        tick(2);
        start      = 1'b1;
        reload_val = 32'h0000_BBBB;
        tick(1);
        start = 1'b0;
        tick(1);
        check("ign_cnt", ctr_cnt_in, 32'h0000_AAAA);
        check("ign_load", ctr_load, 32'd0);
        ovf_in = 1'b1;
        push(K_PERIOD, 32'd0, 1'b0);
        push(K_LOAD, 32'h0000_AAAA, 1'b0);
        tick(1);
        ovf_in = 1'b0;
        tick(2);
        ovf_in = 1'b1;
        push(K_PERIOD, 32'd0, 1'b0);
        push(K_DONE, 32'd0, 1'b0);
        tick(1);
        ovf_in = 1'b0;
        tick(1);
        check("ign_idle", busy, 32'd0);
        drained("ign_drain");

        // Start and stop together in idle: start wins
        stop = 1'b1;
        begin_run(32'h0000_0033, 1'b1, 8'd0);
        stop = 1'b0;
        check("ss_busy", busy, 32'd1);
        tick(1);
        check("ss_en", ctr_enable, 32'd1);

        // Asynchronous reset mid-run
        #3 res_n = 1'b0;
        #1;
        check("mr_ctl", {26'd0, ctr_enable, ctr_load, ctr_dir, busy, period_evt, done}, 32'd0);
        check("mr_cnt", ctr_cnt_in, 32'd0);
        @(negedge clk) res_n = 1'b1;
        tick(2);
        check("mr_busy_after", busy, 32'd0);
        drained("mr_drain");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
